piece_move_ctrl: RTL and testbench

Sequencer for the falling tetromino. Turns keypresses and frame-rate gravity into one-at-a-time move requests to the board collision checker, commits accepted moves to the piece datapath, and runs the lock → line-clear → spawn → game-over flow. Sits between the keyboard keycode register and the piece-position/board blocks.

---
 rtl/tetris_pkg.sv | 34 +++
 rtl/key_edge_detect.sv | 61 ++++++
 rtl/piece_move_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_piece_move_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the falling-piece control path.
//   move_op_t    : move request / commit encoding shared with the checker and datapath
//   ctrl_state_t : piece_move_ctrl sequencer state, plus its state constants
//   KC_*         : default USB keycodes for the piece controls
package tetris_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_DOWN  = 3'd3,
    OP_ROT_L = 3'd4,
    OP_ROT_R = 3'd5,
    OP_SPAWN = 3'd6
  } move_op_t;

  // Plain vector states keep the encoding visible to older tooling.
  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_SPAWN     = 3'd0;
  localparam ctrl_state_t ST_PLAY      = 3'd1;
  localparam ctrl_state_t ST_CHK_REQ   = 3'd2;
  localparam ctrl_state_t ST_CHK_WAIT  = 3'd3;
  localparam ctrl_state_t ST_LOCK      = 3'd4;
  localparam ctrl_state_t ST_LOCK_WAIT = 3'd5;
  localparam ctrl_state_t ST_OVER      = 3'd6;

  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_ROT_L = 8'h1D;
  localparam logic [7:0] KC_ROT_R = 8'h1B;
  localparam logic [7:0] KC_DROP  = 8'h2C;

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: samples the keycode once per frame and flags new presses of mapped keys.
//   Clk, Reset       : system clock, synchronous active-high reset
//   frame_tick       : one-cycle pulse per video frame; keycode is sampled only then
//   keycode          : current key, 0 = none
//   new_press        : combinational, high on a frame_tick that sees a new mapped key
//   press_op         : move op the key maps to (OP_DOWN for the hard-drop key)
//   press_drop       : the key is the hard-drop key
module key_edge_detect
  import tetris_pkg::*;
#(
  parameter logic [7:0] KEY_LEFT  = KC_LEFT,
  parameter logic [7:0] KEY_RIGHT = KC_RIGHT,
  parameter logic [7:0] KEY_DOWN  = KC_DOWN,
  parameter logic [7:0] KEY_ROT_L = KC_ROT_L,
  parameter logic [7:0] KEY_ROT_R = KC_ROT_R,
  parameter logic [7:0] KEY_DROP  = KC_DROP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       new_press,
  output move_op_t   press_op,
  output logic       press_drop
);

  logic [7:0] key_prev_r;
  move_op_t   map_op_s;
  logic       mapped_s;
  logic       drop_s;

  // Translate the raw keycode into a move op; anything unlisted is unmapped.
  always_comb begin
    map_op_s = OP_NONE;
    mapped_s = 1'b0;
    drop_s   = 1'b0;
    case (keycode)
      KEY_LEFT:  begin map_op_s = OP_LEFT;  mapped_s = 1'b1; end
      KEY_RIGHT: begin map_op_s = OP_RIGHT; mapped_s = 1'b1; end
      KEY_DOWN:  begin map_op_s = OP_DOWN;  mapped_s = 1'b1; end
      KEY_ROT_L: begin map_op_s = OP_ROT_L; mapped_s = 1'b1; end
      KEY_ROT_R: begin map_op_s = OP_ROT_R; mapped_s = 1'b1; end
      KEY_DROP:  begin map_op_s = OP_DOWN;  mapped_s = 1'b1; drop_s = 1'b1; end
      default:   begin map_op_s = OP_NONE;  mapped_s = 1'b0; drop_s = 1'b0; end
    endcase
  end

  // Remember the key seen on the last frame so a held key fires only once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_prev_r <= 8'h00;
    end else if (frame_tick) begin
      key_prev_r <= keycode;
    end
  end

  assign new_press  = frame_tick && (keycode != key_prev_r) && (keycode != 8'h00) && mapped_s;
  assign press_op   = map_op_s;
  assign press_drop = drop_s;

endmodule

// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl: sequences key and gravity moves of the falling piece through the
// collision checker, commits accepted moves, and runs lock -> spawn -> game over.
//   Clk, Reset           : system clock, synchronous active-high reset
//   frame_tick, keycode  : frame pulse and current keyboard keycode
//   chk_valid/op/ready   : move-check request handshake to the collision checker
//   res_valid, res_ok    : check result strobe and no-collision flag
//   commit, commit_op    : one-cycle pulse telling the datapath to apply an op
//   lock, lock_done      : lock/line-clear request pulse and its completion
//   game_over            : sticky until Reset
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int         GRAVITY_FRAMES = 24,
  parameter logic [7:0] KEY_LEFT  = KC_LEFT,
  parameter logic [7:0] KEY_RIGHT = KC_RIGHT,
  parameter logic [7:0] KEY_DOWN  = KC_DOWN,
  parameter logic [7:0] KEY_ROT_L = KC_ROT_L,
  parameter logic [7:0] KEY_ROT_R = KC_ROT_R,
  parameter logic [7:0] KEY_DROP  = KC_DROP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       chk_valid,
  output logic [2:0] chk_op,
  input  logic       chk_ready,
  input  logic       res_valid,
  input  logic       res_ok,
  output logic       commit,
  output logic [2:0] commit_op,
  output logic       lock,
  input  logic       lock_done,
  output logic       game_over
);

  localparam int GCW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;

  ctrl_state_t    state_r;
  move_op_t       op_r;
  logic           soft_drop_r;
  logic           drop_mode_r;
  logic [GCW-1:0] grav_cnt_r;
  logic           grav_pending_r;
  logic           key_pending_r;
  move_op_t       key_op_r;
  logic           key_drop_r;
  logic           chk_valid_r;
  move_op_t       chk_op_r;
  logic           commit_r;
  move_op_t       commit_op_r;
  logic           lock_r;
  logic           game_over_r;

  logic           new_press_s;
  move_op_t       press_op_s;
  logic           press_drop_s;
  logic           play_s;
  logic           grav_tc_s;
  logic           grav_clr_s;
  logic           sel_drop_s;
  logic           sel_key_s;
  logic           sel_grav_s;
  logic           work_s;
  move_op_t       sel_op_s;

  key_edge_detect #(
    .KEY_LEFT  (KEY_LEFT),
    .KEY_RIGHT (KEY_RIGHT),
    .KEY_DOWN  (KEY_DOWN),
    .KEY_ROT_L (KEY_ROT_L),
    .KEY_ROT_R (KEY_ROT_R),
    .KEY_DROP  (KEY_DROP)
  ) u_key_edge_detect (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .new_press  (new_press_s),
    .press_op   (press_op_s),
    .press_drop (press_drop_s)
  );

  assign play_s    = (state_r == ST_PLAY);
  assign grav_tc_s = frame_tick && (grav_cnt_r == GCW'(GRAVITY_FRAMES - 1));
  // A successful spawn or key-driven soft drop restarts the gravity period.
  assign grav_clr_s = (state_r == ST_CHK_WAIT) && res_valid && res_ok &&
                      ((op_r == OP_SPAWN) || ((op_r == OP_DOWN) && soft_drop_r));

  // Pick the next request source: hard drop, then key, then gravity.
  always_comb begin
    sel_drop_s = 1'b0;
    sel_key_s  = 1'b0;
    sel_grav_s = 1'b0;
    sel_op_s   = OP_NONE;
    if (drop_mode_r) begin
      sel_drop_s = 1'b1;
      sel_op_s   = OP_DOWN;
    end else if (key_pending_r) begin
      sel_key_s  = 1'b1;
      sel_op_s   = key_drop_r ? OP_DOWN : key_op_r;
    end else if (grav_pending_r) begin
      sel_grav_s = 1'b1;
      sel_op_s   = OP_DOWN;
    end else begin
      sel_op_s   = OP_NONE;
    end
  end

  assign work_s = sel_drop_s || sel_key_s || sel_grav_s;

  // Gravity counter runs in every state; a newly due drop wins over a same-cycle service clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grav_cnt_r     <= '0;
      grav_pending_r <= 1'b0;
    end else if (grav_clr_s) begin
      grav_cnt_r     <= '0;
      grav_pending_r <= 1'b0;
    end else begin
      if (frame_tick) begin
        grav_cnt_r <= grav_tc_s ? '0 : grav_cnt_r + GCW'(1);
      end
      if (grav_tc_s) begin
        grav_pending_r <= 1'b1;
      end else if (play_s && sel_grav_s) begin
        grav_pending_r <= 1'b0;
      end
    end
  end

  // One-deep key slot; a newer press overwrites an unserved one, presses outside PLAY are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_pending_r <= 1'b0;
      key_op_r      <= OP_NONE;
      key_drop_r    <= 1'b0;
    end else if (play_s && new_press_s && !drop_mode_r) begin
      key_pending_r <= 1'b1;
      key_op_r      <= press_op_s;
      key_drop_r    <= press_drop_s;
    end else if (play_s && sel_key_s) begin
      key_pending_r <= 1'b0;
    end
  end

  // Main sequencer with registered handshake, commit, lock and game-over outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_SPAWN;
      op_r        <= OP_NONE;
      soft_drop_r <= 1'b0;
      drop_mode_r <= 1'b0;
      chk_valid_r <= 1'b0;
      chk_op_r    <= OP_NONE;
      commit_r    <= 1'b0;
      commit_op_r <= OP_NONE;
      lock_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      commit_r <= 1'b0;
      lock_r   <= 1'b0;
      case (state_r)
        ST_SPAWN: begin
          op_r        <= OP_SPAWN;
          soft_drop_r <= 1'b0;
          chk_valid_r <= 1'b1;
          chk_op_r    <= OP_SPAWN;
          state_r     <= ST_CHK_REQ;
        end
        ST_PLAY: begin
          if (work_s) begin
            op_r        <= sel_op_s;
            soft_drop_r <= sel_key_s && !key_drop_r && (key_op_r == OP_DOWN);
            chk_valid_r <= 1'b1;
            chk_op_r    <= sel_op_s;
            state_r     <= ST_CHK_REQ;
            if (sel_key_s && key_drop_r) begin
              drop_mode_r <= 1'b1;
            end
          end
        end
        ST_CHK_REQ: begin
          if (chk_ready) begin
            chk_valid_r <= 1'b0;
            state_r     <= ST_CHK_WAIT;
          end
        end
        ST_CHK_WAIT: begin
          if (res_valid) begin
            if (res_ok) begin
              commit_r    <= 1'b1;
              commit_op_r <= op_r;
              state_r     <= ST_PLAY;
            end else if (op_r == OP_DOWN) begin
              drop_mode_r <= 1'b0;
              lock_r      <= 1'b1;
              state_r     <= ST_LOCK;
            end else if (op_r == OP_SPAWN) begin
              game_over_r <= 1'b1;
              state_r     <= ST_OVER;
            end else begin
              state_r     <= ST_PLAY;
            end
          end
        end
        ST_LOCK: begin
          state_r <= ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (lock_done) begin
            state_r <= ST_SPAWN;
          end
        end
        ST_OVER: begin
          state_r <= ST_OVER;
        end
        default: begin
          chk_valid_r <= 1'b0;
          state_r     <= ST_SPAWN;
        end
      endcase
    end
  end

  assign chk_valid = chk_valid_r;
  assign chk_op    = chk_op_r;
  assign commit    = commit_r;
  assign commit_op = commit_op_r;
  assign lock      = lock_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// tb_piece_move_ctrl: directed bench for piece_move_ctrl with a zero-wait checker model.
module tb_piece_move_ctrl;
  import tetris_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       chk_valid;
  logic [2:0] chk_op;
  logic       chk_ready = 1'b1;
  logic       res_valid = 1'b0;
  logic       res_ok = 1'b0;
  logic       commit;
  logic [2:0] commit_op;
  logic       lock;
  logic       lock_done = 1'b0;
  logic       game_over;

  int         errors = 0;
  int         checks = 0;
  int         ok_budget = -1;
  logic [7:0] fail_op = 8'h00;
  int         commit_cnt [8];
  int         lock_cnt = 0;
  int         req_cnt = 0;
  logic [2:0] last_req = 3'd0;
  logic       valid_q = 1'b0;
  logic [2:0] commit_log [$];

  piece_move_ctrl #(.GRAVITY_FRAMES(24)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .chk_valid  (chk_valid),
    .chk_op     (chk_op),
    .chk_ready  (chk_ready),
    .res_valid  (res_valid),
    .res_ok     (res_ok),
    .commit     (commit),
    .commit_op  (commit_op),
    .lock       (lock),
    .lock_done  (lock_done),
    .game_over  (game_over)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame tick followed by idle cycles; called at a negedge.
  task automatic frame(input int idle);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (idle) @(negedge Clk);
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!lock && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, (n < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Zero-wait checker: a handshake seen now is answered right after the next edge.
  initial begin
    logic       hs;
    logic [2:0] op;
    forever begin
      @(negedge Clk);
      hs = chk_valid && chk_ready;
      op = chk_op;
      @(posedge Clk);
      #1;
      res_valid = hs;
      res_ok    = hs && !fail_op[op] && (ok_budget != 0);
      if (hs && res_ok && ok_budget > 0) ok_budget--;
    end
  end

  // Output monitor, sampled just after each active edge.
  initial begin
    for (int i = 0; i < 8; i++) commit_cnt[i] = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (commit) begin
        commit_cnt[commit_op]++;
        commit_log.push_back(commit_op);
      end
      if (lock) lock_cnt++;
      if (chk_valid && !valid_q) begin
        req_cnt++;
        last_req = chk_op;
      end
      valid_q = chk_valid;
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_chk_valid", chk_valid, 32'd0);
    chk("rst_chk_op", chk_op, 32'd0);
    chk("rst_commit", commit, 32'd0);
    chk("rst_commit_op", commit_op, 32'd0);
    chk("rst_lock", lock, 32'd0);
    chk("rst_game_over", game_over, 32'd0);
    Reset = 1'b0;

    // Spawn request and 3-cycle commit latency
    @(negedge Clk);
    chk("spawn_valid", chk_valid, 32'd1);
    chk("spawn_op", chk_op, 32'd6);
    @(negedge Clk);
    chk("spawn_valid_drop", chk_valid, 32'd0);
    @(negedge Clk);
    chk("spawn_commit", commit, 32'd1);
    chk("spawn_commit_op", commit_op, 32'd6);
    repeat (4) @(negedge Clk);

    // Gravity every 24 ticks
    repeat (23) frame(12);
    chk("grav_early", commit_cnt[3], 32'd0);
    frame(12);
    chk("grav_down", commit_cnt[3], 32'd1);

    // Held LEFT fires once, re-press fires again
    keycode = 8'h50;
    repeat (10) frame(12);
    chk("left_held", commit_cnt[1], 32'd1);
    keycode = 8'h00;
    frame(12);
    keycode = 8'h50;
    frame(12);
    chk("left_again", commit_cnt[1], 32'd2);

    // RIGHT on the frame gravity becomes due: key first, then DOWN
    repeat (11) frame(12);
    chk("grav_not_yet", commit_cnt[3], 32'd1);
    commit_log.delete();
    keycode = 8'h4F;
    frame(12);
    chk("key_grav_count", commit_log.size(), 32'd2);
    if (commit_log.size() == 2) begin
      chk("key_first", commit_log[0], 32'd2);
      chk("grav_second", commit_log[1], 32'd3);
    end
    chk("down_after_right", commit_cnt[3], 32'd2);

    // Hard drop: 5 good DOWNs then a failing one locks
    ok_budget = 5;
    keycode = 8'h2C;
    frame(0);
    wait_lock("drop_lock_seen");
    chk("drop_downs", commit_cnt[3], 32'd7);
    repeat (7) @(negedge Clk);
    ok_budget = -1;
    lock_done = 1'b1;
    @(negedge Clk);
    lock_done = 1'b0;
    repeat (6) @(negedge Clk);
    chk("drop_lock_once", lock_cnt, 32'd1);
    chk("respawn_req", last_req, 32'd6);
    chk("respawn_commit", commit_cnt[6], 32'd2);

    // Failing LEFT is discarded and PLAY resumes
    fail_op[1] = 1'b1;
    keycode = 8'h00;
    frame(12);
    keycode = 8'h50;
    frame(12);
    chk("left_fail_req", last_req, 32'd1);
    chk("left_fail_nocommit", commit_cnt[1], 32'd2);
    chk("left_fail_nolock", lock_cnt, 32'd1);
    fail_op = 8'h00;
    keycode = 8'h00;
    frame(12);
    keycode = 8'h4F;
    frame(12);
    chk("play_resumed", commit_cnt[2], 32'd2);

    // Failed spawn ends the game
    fail_op[3] = 1'b1;
    fail_op[6] = 1'b1;
    keycode = 8'h00;
    frame(12);
    keycode = 8'h2C;
    frame(0);
    wait_lock("over_lock_seen");
    repeat (7) @(negedge Clk);
    lock_done = 1'b1;
    @(negedge Clk);
    lock_done = 1'b0;
    repeat (8) @(negedge Clk);
    chk("game_over_set", game_over, 32'd1);
    chk("over_lock_cnt", lock_cnt, 32'd2);
    chk("over_no_spawn_commit", commit_cnt[6], 32'd2);
    fail_op = 8'h00;
    keycode = 8'h00;
    frame(12);
    keycode = 8'h50;
    frame(12);
    keycode = 8'h4F;
    repeat (25) frame(12);
    chk("over_no_requests", req_cnt, 32'd17);
    chk("game_over_sticky", game_over, 32'd1);
    keycode = 8'h00;

    // Reset in the middle of an unanswered request
    chk_ready = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stall_valid_held", chk_valid, 32'd1);
    chk("stall_op", chk_op, 32'd6);
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_drops_valid", chk_valid, 32'd0);
    chk("reset_clears_over", game_over, 32'd0);
    Reset = 1'b0;
    chk_ready = 1'b1;
    @(negedge Clk);
    chk("reset_respawn_req", chk_valid, 32'd1);
    repeat (6) @(negedge Clk);
    chk("reset_respawn_commit", commit_cnt[6], 32'd3);
    repeat (23) frame(12);
    chk("reset_grav_early", commit_cnt[3], 32'd7);
    frame(12);
    chk("reset_grav_down", commit_cnt[3], 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
